// File: rtl/uart_cal_ctrl.sv
// uart_cal_ctrl: command sequencer for the UART calculator.
// Parses "S<A><op><B>=" from the rx byte stream and computes the result.
// A restoring divider and a double-dabble converter produce the decimal
// digits, which are then handed to the tx block one byte at a time.
module uart_cal_ctrl #(
   parameter int MAX_DIG = 4,
   parameter int OPW     = 14,
   parameter int RESW    = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       busy,
   output logic       calc_done,
   output logic       err
);

   localparam int CW = $clog2(MAX_DIG + 1);
   localparam int SW = $clog2(RESW + 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_OPA, ST_OPB, ST_CALC, ST_DIV, ST_CONV, ST_ERR, ST_SEND
   } state_t;

   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

   typedef enum logic [2:0] {PH_SIGN, PH_DIG, PH_CR, PH_LF, PH_ECH} phase_t;

   state_t            state, state_next;
   op_t               op, rx_op;
   phase_t            phase;
   logic [OPW-1:0]    a_reg, b_reg, a_shift, b_shift, dig_val, diff, div_q;
   logic [CW-1:0]     a_cnt, b_cnt;
   logic              neg, a_ge_b, a_full, b_full;
   logic [RESW-1:0]   r_reg, sum, prod;
   logic [OPW:0]      div_rem, rem_next;
   logic [OPW+1:0]    rem_shift, trial;
   logic              fits;
   logic [SW-1:0]     step;
   logic [31:0]       bcd, bcd_next;
   logic [3:0]        dig_left;
   logic              started, hold, err_frame;
   logic              rx_is_dig, rx_is_op, rx_is_s, rx_is_eq, rx_is_sp;
   logic              skip, issue;
   logic [7:0]        cur_byte;

   // One double-dabble step: add 3 to every digit of 5 or more, then shift in the next bit.
   function automatic logic [31:0] dd_step(input logic [31:0] v, input logic bin);
      logic [31:0] o;
      o = v;
      for (int i = 0; i < 8; i++) begin
         if (o[4*i +: 4] >= 4'd5) o[4*i +: 4] = o[4*i +: 4] + 4'd3;
      end
      return {o[30:0], bin};
   endfunction

   assign rx_is_dig = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign rx_is_op  = rx_data inside {8'h2B, 8'h2D, 8'h2A, 8'h2F};
   assign rx_is_s   = (rx_data == 8'h53);
   assign rx_is_eq  = (rx_data == 8'h3D);
   assign rx_is_sp  = (rx_data == 8'h20);

   assign dig_val = OPW'(rx_data[3:0]);
   assign a_shift = a_reg * OPW'(10) + dig_val;
   assign b_shift = b_reg * OPW'(10) + dig_val;
   assign a_full  = (a_cnt == CW'(MAX_DIG));
   assign b_full  = (b_cnt == CW'(MAX_DIG));

   assign a_ge_b = (a_reg >= b_reg);
   assign diff   = a_ge_b ? (a_reg - b_reg) : (b_reg - a_reg);
   assign sum    = RESW'(a_reg) + RESW'(b_reg);
   assign prod   = RESW'(a_reg) * RESW'(b_reg);

   assign rem_shift = {div_rem, div_q[OPW-1]};
   assign trial     = rem_shift - {2'b00, b_reg};
   assign fits      = !trial[OPW+1];
   assign rem_next  = fits ? trial[OPW:0] : rem_shift[OPW:0];

   assign bcd_next = dd_step(bcd, r_reg[RESW-1]);

   assign skip  = (phase == PH_DIG) && !started && (bcd[31:28] == 4'd0) && (dig_left != 4'd1);
   assign issue = (state == ST_SEND) && !skip && !hold && !tx_busy;

   assign busy = !(state inside {ST_IDLE, ST_OPA, ST_OPB});

   // Map the received operator character onto its operation code.
   always_comb begin
      rx_op = OP_ADD;
      case (rx_data)
         8'h2D:   rx_op = OP_SUB;
         8'h2A:   rx_op = OP_MUL;
         8'h2F:   rx_op = OP_DIV;
         default: rx_op = OP_ADD;
      endcase
   end

   // Select the byte the sender would hand to tx in the current phase.
   always_comb begin
      cur_byte = 8'h0A;
      case (phase)
         PH_SIGN: cur_byte = 8'h2D;
         PH_DIG:  cur_byte = {4'h3, bcd[31:28]};
         PH_CR:   cur_byte = 8'h0D;
         PH_ECH:  cur_byte = 8'h45;
         default: cur_byte = 8'h0A;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state logic: frame parsing, arithmetic sequencing and reply completion.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (rx_valid && rx_is_s) state_next = ST_OPA;
         ST_OPA: begin
            if (rx_valid && !rx_is_sp) begin
               if (rx_is_s)        state_next = ST_OPA;
               else if (rx_is_dig) state_next = a_full ? ST_ERR : ST_OPA;
               else if (rx_is_op)  state_next = (a_cnt != '0) ? ST_OPB : ST_ERR;
               else                state_next = ST_ERR;
            end
         end
         ST_OPB: begin
            if (rx_valid && !rx_is_sp) begin
               if (rx_is_s)        state_next = ST_OPA;
               else if (rx_is_dig) state_next = b_full ? ST_ERR : ST_OPB;
               else if (rx_is_eq)  state_next = (b_cnt != '0) ? ST_CALC : ST_ERR;
               else                state_next = ST_ERR;
            end
         end
         ST_CALC: begin
            if (op == OP_DIV) state_next = (b_reg == '0) ? ST_ERR : ST_DIV;
            else              state_next = ST_CONV;
         end
         ST_DIV:  if (step == SW'(OPW - 1)) state_next = ST_CONV;
         ST_CONV: if (step == SW'(RESW - 1)) state_next = ST_SEND;
         ST_ERR:  state_next = ST_SEND;
         ST_SEND: if (issue && (phase == PH_LF)) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, arithmetic, conversion and the byte sender.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         a_cnt     <= '0;
         b_cnt     <= '0;
         op        <= OP_ADD;
         neg       <= 1'b0;
         r_reg     <= '0;
         div_q     <= '0;
         div_rem   <= '0;
         step      <= '0;
         bcd       <= '0;
         phase     <= PH_DIG;
         dig_left  <= 4'd8;
         started   <= 1'b0;
         hold      <= 1'b0;
         err_frame <= 1'b0;
         tx_data   <= 8'h00;
         tx_start  <= 1'b0;
         calc_done <= 1'b0;
         err       <= 1'b0;
      end else begin
         tx_start  <= 1'b0;
         calc_done <= 1'b0;
         err       <= (state_next == ST_ERR);
         case (state)
            ST_IDLE: begin
               if (rx_valid && rx_is_s) begin
                  a_reg <= '0;
                  a_cnt <= '0;
               end
            end
            ST_OPA: begin
               if (rx_valid) begin
                  if (rx_is_s) begin
                     a_reg <= '0;
                     a_cnt <= '0;
                  end else if (rx_is_dig && !a_full) begin
                     a_reg <= a_shift;
                     a_cnt <= a_cnt + CW'(1);
                  end else if (rx_is_op && (a_cnt != '0)) begin
                     op    <= rx_op;
                     b_reg <= '0;
                     b_cnt <= '0;
                  end
               end
            end
            ST_OPB: begin
               if (rx_valid) begin
                  if (rx_is_s) begin
                     a_reg <= '0;
                     a_cnt <= '0;
                  end else if (rx_is_dig && !b_full) begin
                     b_reg <= b_shift;
                     b_cnt <= b_cnt + CW'(1);
                  end
               end
            end
            ST_CALC: begin
               neg     <= 1'b0;
               bcd     <= '0;
               step    <= '0;
               div_q   <= a_reg;
               div_rem <= '0;
               case (op)
                  OP_ADD: r_reg <= sum;
                  OP_SUB: begin
                     r_reg <= RESW'(diff);
                     neg   <= !a_ge_b;
                  end
                  OP_MUL: r_reg <= prod;
                  default: r_reg <= '0;
               endcase
            end
            ST_DIV: begin
               div_q   <= {div_q[OPW-2:0], fits};
               div_rem <= rem_next;
               step    <= step + SW'(1);
               if (step == SW'(OPW - 1)) begin
                  r_reg <= RESW'({div_q[OPW-2:0], fits});
                  step  <= '0;
               end
            end
            ST_CONV: begin
               bcd   <= bcd_next;
               r_reg <= {r_reg[RESW-2:0], 1'b0};
               step  <= step + SW'(1);
               if (step == SW'(RESW - 1)) begin
                  phase     <= neg ? PH_SIGN : PH_DIG;
                  dig_left  <= 4'd8;
                  started   <= 1'b0;
                  hold      <= 1'b0;
                  err_frame <= 1'b0;
               end
            end
            ST_ERR: begin
               phase     <= PH_ECH;
               hold      <= 1'b0;
               err_frame <= 1'b1;
            end
            ST_SEND: begin
               hold <= 1'b0;
               if (skip) begin
                  bcd      <= {bcd[27:0], 4'h0};
                  dig_left <= dig_left - 4'd1;
               end else if (issue) begin
                  tx_data  <= cur_byte;
                  tx_start <= 1'b1;
                  hold     <= 1'b1;
                  case (phase)
                     PH_SIGN: phase <= PH_DIG;
                     PH_DIG: begin
                        started <= 1'b1;
                        bcd     <= {bcd[27:0], 4'h0};
                        if (dig_left == 4'd1) phase <= PH_CR;
                        else                  dig_left <= dig_left - 4'd1;
                     end
                     PH_ECH:  phase <= PH_CR;
                     PH_CR:   phase <= PH_LF;
                     default: calc_done <= !err_frame;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cal_ctrl.sv
// tb_uart_cal_ctrl: scoreboard bench for the UART calculator sequencer.
// Frames are fed as rx strobes; a string-level reference model queues the
// expected reply bytes, and a monitor pops and compares every tx_start.
module tb_uart_cal_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_busy;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       busy;
   logic       calc_done;
   logic       err;

   byte unsigned exp_q[$];
   int compared  = 0;
   int failed    = 0;
   int err_seen  = 0;
   int done_seen = 0;
   int err_exp   = 0;
   int done_exp  = 0;
   int tx_count  = 0;

   int m_mode = 0;
   int m_a, m_b, m_na, m_nb;
   byte unsigned m_op;

   uart_cal_ctrl #(.MAX_DIG(4), .OPW(14), .RESW(27)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_busy   (tx_busy),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .busy      (busy),
      .calc_done (calc_done),
      .err       (err)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic flagFail(input string name, input logic [31:0] actual);
      compared++;
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected no such event", name, actual);
   endtask

   task automatic pushString(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic modelError();
      pushString("E");
      err_exp++;
   endtask

   // Evaluate the completed frame with plain integer arithmetic.
   task automatic modelResult();
      int r;
      string s;
      r = 0;
      s = "";
      if (m_op == 8'h2F && m_b == 0) begin
         modelError();
         return;
      end
      case (m_op)
         8'h2B: r = m_a + m_b;
         8'h2D: r = (m_a >= m_b) ? m_a - m_b : m_b - m_a;
         8'h2A: r = m_a * m_b;
         default: r = m_a / m_b;
      endcase
      s = $sformatf("%0d", r);
      if (m_op == 8'h2D && m_a < m_b) s = {"-", s};
      pushString(s);
      done_exp++;
   endtask

   // Reference parser: one received byte, returns term=1 once a reply is due.
   task automatic modelByte(input byte unsigned c, output bit term);
      bit is_dig;
      term   = 1'b0;
      is_dig = (c >= 8'h30 && c <= 8'h39);
      if (m_mode == 0) begin
         if (c == 8'h53) begin m_mode = 1; m_a = 0; m_na = 0; end
      end else if (c == 8'h20) begin
      end else if (c == 8'h53) begin
         m_mode = 1; m_a = 0; m_na = 0;
      end else if (m_mode == 1) begin
         if (is_dig && m_na < 4) begin m_a = m_a * 10 + (c - 8'h30); m_na++; end
         else if ((c inside {8'h2B, 8'h2D, 8'h2A, 8'h2F}) && m_na > 0) begin
            m_op = c; m_b = 0; m_nb = 0; m_mode = 2;
         end else begin modelError(); term = 1'b1; end
      end else begin
         if (is_dig && m_nb < 4) begin m_b = m_b * 10 + (c - 8'h30); m_nb++; end
         else if (c == 8'h3D && m_nb > 0) begin modelResult(); term = 1'b1; end
         else begin modelError(); term = 1'b1; end
      end
      if (term) m_mode = 0;
   endtask

   task automatic sendBytes(input string s, output bit term);
      term = 1'b0;
      for (int i = 0; i < s.len() && !term; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         @(negedge clk);
         #1;
         rx_data  = s[i];
         rx_valid = 1'b1;
         modelByte(s[i], term);
         @(negedge clk);
         #1;
         rx_valid = 1'b0;
      end
   endtask

   // Wait for the queued reply to drain, optionally pushing junk while busy.
   task automatic waitReply(input bit inject);
      int n;
      byte unsigned junk[6];
      junk = '{8'h53, 8'h31, 8'h2B, 8'h3D, 8'h20, 8'h39};
      n = 0;
      while (!(exp_q.size() == 0 && !busy)) begin
         @(negedge clk);
         #1;
         rx_valid = 1'b0;
         if (inject && busy && $urandom_range(0, 4) == 0) begin
            rx_data  = junk[$urandom_range(0, 5)];
            rx_valid = 1'b1;
         end
         n++;
         if (n > 6000) begin
            flagFail("reply_timeout", exp_q.size());
            exp_q.delete();
            break;
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic applyStimulus(input string s, input bit inject);
      bit term;
      sendBytes(s, term);
      if (!term) sendBytes("S1+1=", term);
      waitReply(inject);
      repeat (4) @(negedge clk);
      #1;
      checkOutput({"err_count ", s}, err_seen, err_exp);
      checkOutput({"done_count ", s}, done_seen, done_exp);
   endtask

   function automatic string genFrame();
      int kind, nda, ndb, a, b, lim;
      byte unsigned opc;
      string ops, sa, sb;
      ops  = "+-*/";
      kind = $urandom_range(0, 11);
      nda  = $urandom_range(1, 4);
      ndb  = $urandom_range(1, 4);
      lim = 1; repeat (nda) lim *= 10;
      a   = $urandom_range(0, lim - 1);
      lim = 1; repeat (ndb) lim *= 10;
      b   = $urandom_range(0, lim - 1);
      opc = ops[$urandom_range(0, 3)];
      sa  = $sformatf("%0d", a);
      sb  = $sformatf("%0d", b);
      case (kind)
         0: sa = $sformatf("0%0d", a % 1000);
         1: sa = $sformatf("%0d", $urandom_range(10000, 99999));
         2: begin opc = 8'h2F; sb = "0"; end
         3: return $sformatf("S %s %c %s =", sa, opc, sb);
         4: return $sformatf("x?S%s%c%s=", sa, opc, sb);
         5: return $sformatf("S%s%cS%s%c%s=", sa, opc, sb, opc, sa);
         6: return $sformatf("S%s%c%c%s=", sa, opc, opc, sb);
         7: return $sformatf("S%s%c=", sa, opc);
         default: ;
      endcase
      return $sformatf("S%s%c%s=", sa, opc, sb);
   endfunction

   // Scoreboard monitor: every byte handed to tx must match the head of the queue.
   initial begin
      byte unsigned want;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (tx_start) begin
               tx_count++;
               if (exp_q.size() == 0) flagFail("unexpected_tx", tx_data);
               else begin
                  want = exp_q.pop_front();
                  checkOutput("tx_byte", tx_data, want);
               end
            end
            if (calc_done) begin
               done_seen++;
               checkOutput("done_with_lf", {tx_start, tx_data}, {1'b1, 8'h0A});
            end
            if (err) err_seen++;
         end
      end
   end

   // Behavioural tx block: busy for a random time per byte, data must stay put.
   initial begin
      byte unsigned held;
      int left;
      held    = 8'h00;
      left    = 0;
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            tx_busy = 1'b0;
            left    = 0;
         end else if (tx_start) begin
            if (tx_busy) flagFail("tx_start_while_busy", tx_data);
            held    = tx_data;
            tx_busy = 1'b1;
            left    = $urandom_range(3, 24);
         end else if (tx_busy) begin
            checkOutput("tx_data_stable", tx_data, held);
            left--;
            if (left == 0) tx_busy = 1'b0;
         end
      end
   end

   // Hard stop in case a wait is never satisfied.
   initial begin
      #900000;
      flagFail("global_timeout", 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

   // Main sequence: reset, directed frames, random frames, reset mid-reply.
   initial begin
      bit term;
      int start_cnt, rst_cnt, n;
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_tx_data", tx_data, 8'h00);
      checkOutput("reset_tx_start", tx_start, 1'b0);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_calc_done", calc_done, 1'b0);
      checkOutput("reset_err", err, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      applyStimulus("S1234+5678=", 1'b1);
      applyStimulus("S12-345=", 1'b0);
      applyStimulus("S5-5=", 1'b0);
      applyStimulus("S9999*9999=", 1'b1);
      applyStimulus("S100/7=", 1'b0);
      applyStimulus("S7/0=", 1'b0);
      applyStimulus("S12345+1=", 1'b0);
      applyStimulus("S+3=", 1'b0);
      applyStimulus("S3+x", 1'b0);
      applyStimulus("S9+S2*3=", 1'b1);
      applyStimulus("S 1 + 2 =", 1'b0);
      applyStimulus("S0*0=", 1'b0);

      for (int k = 0; k < 40; k++) applyStimulus(genFrame(), 1'($urandom_range(0, 1)));

      sendBytes("S9999*9999=", term);
      start_cnt = tx_count;
      n = 0;
      while (tx_count < start_cnt + 1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) flagFail("first_digit_timeout", tx_count);
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      done_exp--;
      m_mode  = 0;
      rst_cnt = tx_count;
      #1;
      checkOutput("midsend_tx_data", tx_data, 8'h00);
      checkOutput("midsend_tx_start", tx_start, 1'b0);
      checkOutput("midsend_busy", busy, 1'b0);
      checkOutput("midsend_calc_done", calc_done, 1'b0);
      checkOutput("midsend_err", err, 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      repeat (400) @(negedge clk);
      #1;
      checkOutput("tx_after_rst", tx_count, rst_cnt);
      checkOutput("done_after_rst", done_seen, done_exp);
      applyStimulus("S2+2=", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule

// File: doc/uart_cal_ctrl.md
Name: uart_cal_ctrl

Overview:
Command sequencer for the UART calculator. Consumes bytes from the rx block (rx_data/rx_valid) and parses an ASCII expression "S<A><op><B>=". It computes the result with an internal add/sub/mul unit and a sequential divider, converts the result to decimal ASCII, and drives the tx block byte by byte, ending each reply with CR LF. It sits between rx and tx at the top of the UART_CAL design.

Parameters:
MAX_DIG, 4, maximum decimal digits per operand (operands 0..9999)
OPW, 14, operand width in bits; must satisfy 2^OPW > 10^MAX_DIG - 1
RESW, 27, magnitude result width; covers 9999*9999 = 99980001

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
rx_data  in  8  received byte, valid only while rx_valid=1
rx_valid  in  1  one-cycle strobe per received byte
tx_busy  in  1  tx block is shifting a byte
tx_data  out  8  byte to transmit, held stable from tx_start until tx_busy falls
tx_start  out  1  one-cycle request to send tx_data
busy  out  1  high in every state except IDLE, OPA and OPB
calc_done  out  1  one-cycle pulse when the reply terminator LF has been handed to tx
err  out  1  one-cycle pulse when a frame is rejected

Behaviour:
- Reset: state=IDLE; A=B=0; digit counters=0; tx_data=8'h00; tx_start=busy=calc_done=err=0. Reset takes effect at any time, including mid-SEND; a partly sent reply is abandoned.
- Space (0x20) is ignored in IDLE, OPA and OPB.
- IDLE: 'S' (0x53) goes to OPA and clears A and its digit count. Every other byte is dropped silently.
- OPA: a digit ('0'..'9') updates A = A*10 + (byte - 0x30) and increments the count.
  - An operator '+' 0x2B, '-' 0x2D, '*' 0x2A or '/' 0x2F latches op and goes to OPB. This requires count >= 1; otherwise the frame goes to ERR.
  - A digit arriving when count = MAX_DIG goes to ERR.
  - 'S' restarts the frame: back to OPA with A and its count cleared.
  - Any other byte goes to ERR.
- OPB: digit handling is the same as OPA, applied to B.
  - '=' (0x3D) with count >= 1 goes to CALC; '=' with count = 0 goes to ERR.
  - 'S' restarts the frame and goes to OPA.
  - Any other byte, including a second operator, goes to ERR.
- CALC takes one cycle:
  - '+': R = A + B.
  - '-': when A >= B, R = A - B and neg=0; otherwise R = B - A and neg=1.
  - '*': R = A*B.
  - '/': when B = 0, go to ERR; otherwise go to DIV.
  - All other ops go to CONV.
- DIV: restoring division, one quotient bit per cycle, OPW cycles. The quotient goes to R; the remainder is discarded. Then go to CONV.
- CONV: sequential double-dabble of R into 8 BCD digits, RESW cycles. Then go to SEND.
- SEND byte order:
  - '-' first, if neg=1.
  - Then the decimal digits with leading zeros suppressed. R = 0 sends a single '0'.
  - Then 0x0D, then 0x0A.
- ERR: sends 'E' (0x45), 0x0D, 0x0A, using the same sender. err pulses on the cycle ERR is entered.
- Per-byte handshake:
  - Wait until tx_busy = 0.
  - Drive tx_data and pulse tx_start for one cycle.
  - Ignore tx_busy for the following cycle.
  - Then wait for tx_busy = 0 before issuing the next byte.
- After the final LF is issued: calc_done pulses (successful frames only), then go to IDLE.
- While busy = 1, all rx_valid strobes are dropped, including 'S'. No queuing.
- rx_valid on the same cycle as a state transition is evaluated against the current state only.
- Arithmetic is unsigned throughout; the sign is carried only in neg. Maximum reply is 8 digits + CR LF; no other overflow is possible.

Test Plan:
- "S1234+5678=" at 16 clk/bit through rx -> tx bytes "6912",0x0D,0x0A; calc_done pulses once; err never asserts.
- "S12-345=" -> "-333",CR,LF; then "S5-5=" -> "0",CR,LF.
- "S9999*9999=" -> "99980001",CR,LF; then "S100/7=" -> "14",CR,LF after 14 DIV cycles.
- Error frames, each -> err pulse, "E",CR,LF, return to IDLE:
  - "S7/0="
  - "S12345+1=" (fifth digit)
  - "S+3="
  - "S3+x"
- Restart and ignore rules:
  - "S9+S2*3=" -> "6",CR,LF.
  - Spaces inside "S 1 + 2 =" are ignored -> "3",CR,LF.
  - Bytes injected while busy=1 are dropped and do not corrupt the reply.
- Assert rst during SEND after the first digit -> tx_start stops and all outputs return to reset values; a following "S2+2=" -> "4",CR,LF.
